// File: rtl/fpu_arb_pkg.sv
// Shared types and constants for the fadd/fsub requester arbiter.
package fpu_arb_pkg;

    localparam int FW      = 32;
    localparam int IDW_MAX = 8;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    typedef struct packed {
        logic               valid;
        logic [IDW_MAX-1:0] id;
    } tag_t;

    typedef struct packed {
        logic [IDW_MAX-1:0] id;
        logic [FW-1:0]      y;
        logic               ovf;
    } entry_t;

    // Subtraction is an add with operand 2's sign bit inverted.
    function automatic logic [FW-1:0] flip_sign(input logic [FW-1:0] x, input logic op);
        return {x[FW-1] ^ (op != OP_ADD), x[FW-2:0]};
    endfunction

endpackage

// File: rtl/fpu_arb_fifo.sv
// In-order synchronous result FIFO with wrap-around pointers and a registered count.
module fpu_arb_fifo #(
    parameter int  DEPTH   = 4,
    parameter type entry_t = logic,
    parameter int  CW      = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          push,
    input  entry_t        push_data,
    input  logic          pop,
    output entry_t        head,
    output logic [CW-1:0] count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    entry_t        mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          pop_ok;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign pop_ok = pop && (count != '0);
    assign head   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= next_ptr(wr_ptr);
            end
            if (pop_ok) rd_ptr <= next_ptr(rd_ptr);
            if (push && !pop_ok)      count <= count + 1'b1;
            else if (!push && pop_ok) count <= count - 1'b1;
        end
    end

endmodule

// File: rtl/fpu_addsub_arb.sv
// Round-robin sharing of one fixed-latency FP add/sub unit with a credit-protected result FIFO.
// Optional statistics counters are built when FPU_ARB_STATS_EN is defined.
module fpu_addsub_arb
    import fpu_arb_pkg::*;
#(
    parameter int  NREQ  = 2,
    parameter int  LAT   = 2,
    parameter int  DEPTH = 4,
    localparam int IDW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [NREQ-1:0]  req_valid,
    output logic [NREQ-1:0]  req_ready,
    input  logic [NREQ-1:0]  req_sub,
    input  logic [32*NREQ-1:0] req_x1,
    input  logic [32*NREQ-1:0] req_x2,
    output logic [31:0]      u_x1,
    output logic [31:0]      u_x2,
    input  logic [31:0]      u_y,
    input  logic             u_ovf,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [IDW-1:0]   rsp_id,
    output logic [31:0]      rsp_y,
    output logic             rsp_ovf,
    output logic [31:0]      stat_issued,
    output logic [31:0]      stat_stall
);

    localparam int FCW = $clog2(DEPTH + 1);
    localparam int CW  = $clog2(LAT + DEPTH + 1);

    tag_t           tag_q [LAT];
    logic [IDW-1:0] ptr;
    logic [IDW-1:0] g;
    logic           grant;
    logic [FCW-1:0] occ;
    logic [CW-1:0]  inflight;
    logic           can_issue;
    logic           push;
    logic           pop;
    entry_t         push_data;
    entry_t         head;

    // Every op in flight already owns a FIFO slot, so the non-stallable pipe can always write back.
    always_comb begin
        inflight = '0;
        for (int i = 0; i < LAT; i++) inflight = inflight + CW'(tag_q[i].valid);
    end

    assign can_issue = (inflight + CW'(occ)) < CW'(DEPTH);

    always_comb begin
        grant = 1'b0;
        g     = '0;
        for (int k = 1; k <= NREQ; k++) begin
            if (!grant && can_issue && rstn && req_valid[(int'(ptr) + k) % NREQ]) begin
                grant = 1'b1;
                g     = IDW'((int'(ptr) + k) % NREQ);
            end
        end
    end

    assign req_ready = grant ? (NREQ'(1) << g) : '0;
    assign u_x1      = grant ? req_x1[int'(g)*FW +: FW] : '0;
    assign u_x2      = grant ? flip_sign(req_x2[int'(g)*FW +: FW], req_sub[g]) : '0;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            ptr <= IDW'(NREQ - 1);
            for (int i = 0; i < LAT; i++) tag_q[i] <= '0;
        end else begin
            tag_q[0].valid <= grant;
            tag_q[0].id    <= IDW_MAX'(g);
            for (int i = 1; i < LAT; i++) tag_q[i] <= tag_q[i-1];
            if (grant) ptr <= g;
        end
    end

    assign push         = tag_q[LAT-1].valid;
    assign push_data.id = tag_q[LAT-1].id;
    assign push_data.y  = u_y;
    assign push_data.ovf = u_ovf;
    assign pop          = rsp_valid && rsp_ready;

    fpu_arb_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (entry_t),
        .CW      (FCW)
    ) u_fifo (
        .clk       (clk),
        .rstn      (rstn),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .head      (head),
        .count     (occ)
    );

    assign rsp_valid = (occ != '0);
    assign rsp_id    = IDW'(head.id);
    assign rsp_y     = head.y;
    assign rsp_ovf   = head.ovf;

    assert property (@(posedge clk) disable iff (!rstn) push |-> (occ < FCW'(DEPTH)));

`ifdef FPU_ARB_STATS_EN
    always_ff @(posedge clk) begin
        if (!rstn) begin
            stat_issued <= '0;
            stat_stall  <= '0;
        end else begin
            if (grant)                      stat_issued <= stat_issued + 1'b1;
            if ((|req_valid) && !can_issue) stat_stall  <= stat_stall + 1'b1;
        end
    end
`else
    assign stat_issued = '0;
    assign stat_stall  = '0;
`endif

endmodule
